// File: rtl/package_feeder_pkg.sv
// Definitions shared by the feeder, the package sorter and their benches:
// the weight bus width, the counter width and the feeder state encodings.
package package_feeder_pkg;

  localparam int WEIGHT_W = 12;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/package_feeder_if.sv
// Upstream valid/ready package handshake into the feeder.
// The producer uses the master side and the feeder uses the slave side.
interface package_feeder_if #(
  parameter int W = package_feeder_pkg::WEIGHT_W
);

  logic [W-1:0] in_weight;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_weight, output in_valid, input in_ready);
  modport slave  (input in_weight, input in_valid, output in_ready);

endinterface

// File: rtl/package_feeder_fifo.sv
// Small synchronous FIFO that buffers package weights ahead of the bus FSM.
// The head entry is visible on head_o before it is popped.
module feeder_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [PW:0]   count_q;
  logic          doPush;
  logic          doPop;

  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];

  // Depth is a power of two, so pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/package_feeder.sv
// Transmitter end of the weight/gap protocol: buffers packages from upstream
// and replays each as HOLD_CYCLES of weight followed by GAP_CYCLES of zero.
module package_feeder
  import package_feeder_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  package_feeder_if.slave     up,
  output logic [WEIGHT_W-1:0] weight,
  output logic                busy,
  output logic [CNT_W-1:0]    sent_count,
  output logic [CNT_W-1:0]    drop_count
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  feeder_state_e       state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WEIGHT_W-1:0] weight_q, weight_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic                fifoFull;
  logic                fifoEmpty;
  logic [WEIGHT_W-1:0] fifoHead;
  logic                accept;
  logic                pushEn;
  logic                dropEn;
  logic                popEn;

  // Ready is held low while reset is asserted even though the FIFO is empty.
  assign up.in_ready = reset && !fifoFull;
  assign accept      = up.in_valid && up.in_ready;
  assign pushEn      = accept && (up.in_weight != '0);
  assign dropEn      = accept && (up.in_weight == '0);

  feeder_fifo #(
    .W     (WEIGHT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .data_i  (up.in_weight),
    .head_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      weight_q <= '0;
      sent_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
      sent_q   <= sent_d;
      drop_q   <= drop_d;
    end
  end

  // Loading from GAP as well as IDLE gives back-to-back packages no idle cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;
    sent_d   = sent_q;
    popEn    = 1'b0;
    case (state_q)
      IDLE: begin
        weight_d = '0;
        if (!fifoEmpty) begin
          popEn    = 1'b1;
          weight_d = fifoHead;
          cnt_d    = HOLD_LOAD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          weight_d = '0;
          sent_d   = sent_q + 1'b1;
          cnt_d    = GAP_LOAD;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!fifoEmpty) begin
          popEn    = 1'b1;
          weight_d = fifoHead;
          cnt_d    = HOLD_LOAD;
          state_d  = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        weight_d = '0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (dropEn && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  assign weight     = weight_q;
  assign busy       = !fifoEmpty || (state_q != IDLE);
  assign sent_count = sent_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_package_feeder.sv
// Directed bench for package_feeder: four instances with different hold/gap
// timing share one upstream driver; each test targets one instance.
module tb_package_feeder;

  logic        clk = 1'b0;
  logic        resetN;
  logic [11:0] inWeight;
  logic        inValid;

  logic [11:0] wgt   [4];
  logic [7:0]  sent  [4];
  logic [7:0]  drop  [4];
  logic [3:0]  busyV;
  logic [3:0]  rdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  package_feeder_if if0 ();
  package_feeder_if if1 ();
  package_feeder_if if2 ();
  package_feeder_if if3 ();

  assign if0.in_weight = inWeight;
  assign if0.in_valid  = inValid;
  assign if1.in_weight = inWeight;
  assign if1.in_valid  = inValid;
  assign if2.in_weight = inWeight;
  assign if2.in_valid  = inValid;
  assign if3.in_weight = inWeight;
  assign if3.in_valid  = inValid;
  assign rdy = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};

  package_feeder #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(resetN), .up(if0), .weight(wgt[0]), .busy(busyV[0]),
    .sent_count(sent[0]), .drop_count(drop[0]));
  package_feeder #(.HOLD_CYCLES(8), .GAP_CYCLES(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(resetN), .up(if1), .weight(wgt[1]), .busy(busyV[1]),
    .sent_count(sent[1]), .drop_count(drop[1]));
  package_feeder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(resetN), .up(if2), .weight(wgt[2]), .busy(busyV[2]),
    .sent_count(sent[2]), .drop_count(drop[2]));
  package_feeder #(.HOLD_CYCLES(3), .GAP_CYCLES(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .reset(resetN), .up(if3), .weight(wgt[3]), .busy(busyV[3]),
    .sent_count(sent[3]), .drop_count(drop[3]));

  logic [11:0] t1In  [6]  = '{100, 250, 550, 801, 1001, 2001};
  logic [11:0] t1Exp [15] = '{0, 100, 0, 250, 0, 550, 0, 801, 0, 1001, 0, 2001, 0, 0, 0};
  logic [11:0] t2In  [6]  = '{11, 22, 33, 44, 55, 66};
  logic [11:0] t3Exp [5]  = '{0, 0, 300, 0, 0};
  logic [11:0] t4Exp [8]  = '{0, 77, 77, 77, 77, 0, 0, 0};
  logic [11:0] t7Exp [12] = '{0, 7, 7, 7, 0, 0, 9, 9, 9, 0, 0, 0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one package to instance sel, waiting (bounded) for its ready.
  task automatic applyStimulus(input int sel, input logic [11:0] w);
    int n;
    n = 0;
    inWeight = w;
    inValid  = 1'b1;
    while (!rdy[sel] && n < 200) begin
      tick();
      n++;
    end
    if (!rdy[sel]) checkOutput("push_wait", {31'd0, rdy[sel]}, 1);
    tick();
    inValid = 1'b0;
  endtask

  task automatic waitIdle(input int sel);
    int n;
    n = 0;
    while (busyV[sel] && n < 2000) begin
      tick();
      n++;
    end
    checkOutput("idle_wait", {31'd0, busyV[sel]}, 0);
  endtask

  task automatic doReset;
    inValid  = 1'b0;
    inWeight = '0;
    resetN   = 1'b0;
    @(posedge clk);
    #4;
    resetN = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pushIdx, seenIdx, holdLen, acceptEdge, nonZero;
    logic [11:0] prevW;
    logic r;

    resetN   = 1'b0;
    inValid  = 1'b0;
    inWeight = '0;
    #2;
    checkOutput("rst_ready",  {31'd0, rdy[0]}, 0);
    checkOutput("rst_weight", wgt[0], 0);
    checkOutput("rst_busy",   {31'd0, busyV[0]}, 0);
    checkOutput("rst_sent",   sent[0], 0);
    checkOutput("rst_drop",   drop[0], 0);
    @(posedge clk);
    #4;
    resetN = 1'b1;
    tick();
    checkOutput("ready_after_release", {31'd0, rdy[0]}, 1);

    // Six back-to-back packages, hold 1 / gap 1.
    doReset();
    for (int k = 1; k <= 15; k++) begin
      if (k <= 6) begin
        inValid  = 1'b1;
        inWeight = t1In[k-1];
      end else begin
        inValid = 1'b0;
      end
      tick();
      checkOutput($sformatf("t1_weight_c%0d", k), wgt[0], t1Exp[k-1]);
      checkOutput($sformatf("t1_busy_c%0d", k), {31'd0, busyV[0]}, (k <= 13) ? 1 : 0);
    end
    checkOutput("t1_sent", sent[0], 6);

    // Hold 8: FIFO fills, sixth offer stalls until the first pop from full.
    doReset();
    pushIdx = 0; seenIdx = 0; holdLen = 0; acceptEdge = 0; prevW = '0;
    for (int c = 1; c <= 90; c++) begin
      if (pushIdx < 6) begin
        inValid  = 1'b1;
        inWeight = t2In[pushIdx];
      end else begin
        inValid = 1'b0;
      end
      r = rdy[1];
      if (c == 6) checkOutput("t2_ready_6th_offer", {31'd0, r}, 0);
      tick();
      if (inValid && r) begin
        pushIdx++;
        if (pushIdx == 6) acceptEdge = c;
      end
      if (c == 2) checkOutput("t2_first_pop", wgt[1], 11);
      if (wgt[1] != 0 && prevW != 0 && wgt[1] != prevW)
        checkOutput("t2_adjacent", wgt[1], prevW);
      if (wgt[1] != 0) begin
        if (prevW == 0) begin
          if (seenIdx < 6) checkOutput($sformatf("t2_order%0d", seenIdx), wgt[1], t2In[seenIdx]);
          seenIdx++;
          holdLen = 1;
        end else begin
          holdLen++;
        end
      end else if (prevW != 0) begin
        checkOutput("t2_hold_len", holdLen, 8);
      end
      prevW = wgt[1];
    end
    inValid = 1'b0;
    checkOutput("t2_accept_edge_6th", acceptEdge, 12);
    checkOutput("t2_seen", seenIdx, 6);
    checkOutput("t2_sent", sent[1], 6);

    // Zero-weight package is dropped, then 300 goes out.
    doReset();
    for (int k = 1; k <= 5; k++) begin
      inValid  = (k <= 2);
      inWeight = (k == 1) ? 12'd0 : 12'd300;
      tick();
      checkOutput($sformatf("t3_weight_c%0d", k), wgt[0], t3Exp[k-1]);
      if (k == 1) checkOutput("t3_drop_early", drop[0], 1);
    end
    checkOutput("t3_drop", drop[0], 1);
    checkOutput("t3_sent", sent[0], 1);

    // Reset in the middle of a hold of 1013 with another package buffered.
    doReset();
    inValid = 1'b1; inWeight = 12'd0;    tick();
    inWeight = 12'd1013;                 tick();
    inWeight = 12'd500;                  tick();
    checkOutput("t4_weight_hold_a", wgt[2], 1013);
    inValid = 1'b0;                      tick();
    checkOutput("t4_weight_hold_b", wgt[2], 1013);
    checkOutput("t4_drop_before", drop[2], 1);
    resetN = 1'b0;
    #2;
    checkOutput("t4_weight_async", wgt[2], 0);
    checkOutput("t4_busy_async",   {31'd0, busyV[2]}, 0);
    checkOutput("t4_ready_async",  {31'd0, rdy[2]}, 0);
    checkOutput("t4_sent_async",   sent[2], 0);
    checkOutput("t4_drop_async",   drop[2], 0);
    @(posedge clk);
    #4;
    resetN = 1'b1;
    tick();
    checkOutput("t4_busy_after", {31'd0, busyV[2]}, 0);
    for (int k = 1; k <= 8; k++) begin
      inValid  = (k == 1);
      inWeight = 12'd77;
      tick();
      checkOutput($sformatf("t4_resume_c%0d", k), wgt[2], t4Exp[k-1]);
    end
    checkOutput("t4_resume_sent", sent[2], 1);

    // Sent counter wraps after 256 packages.
    doReset();
    for (int i = 0; i < 255; i++) applyStimulus(0, 12'd5);
    waitIdle(0);
    checkOutput("t5_sent_255", sent[0], 255);
    applyStimulus(0, 12'd5);
    waitIdle(0);
    checkOutput("t5_sent_wrap", sent[0], 0);
    applyStimulus(0, 12'd5);
    waitIdle(0);
    checkOutput("t5_sent_after_wrap", sent[0], 1);

    // Drop counter saturates.
    doReset();
    nonZero = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 12'd0);
      if (wgt[0] != 0) nonZero++;
      if (i == 253) checkOutput("t6_drop_254", drop[0], 254);
    end
    checkOutput("t6_drop_sat", drop[0], 255);
    checkOutput("t6_no_bus", nonZero, 0);
    checkOutput("t6_sent", sent[0], 0);

    // Hold 3 / gap 2 timing.
    doReset();
    for (int k = 1; k <= 12; k++) begin
      inValid  = (k <= 2);
      inWeight = (k == 1) ? 12'd7 : 12'd9;
      tick();
      checkOutput($sformatf("t7_weight_c%0d", k), wgt[3], t7Exp[k-1]);
    end
    checkOutput("t7_sent", sent[3], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/package_feeder.md
Name: package_feeder

Overview:
- Drives the scale-side weight bus consumed by the package sorter. It is the transmitter end of the weight/gap protocol: one package equals a nonzero weight held on the bus, followed by a zero-weight gap.
- Upstream logic (stimulus generator or conveyor controller) hands packages in through a valid/ready handshake.
- Packages are buffered in a small FIFO and replayed onto the bus with programmable hold and gap timing.
- The block keeps counts of packages sent and zero-weight packages dropped.

Parameters:
WEIGHT_W, 12, weight bus width (matches sorter input)
HOLD_CYCLES, 1, clock cycles a nonzero weight is held on the bus; must be >= 1
GAP_CYCLES, 1, clock cycles of weight==0 after each package; must be >= 1
FIFO_DEPTH, 4, input buffer entries; power of two, >= 2
CNT_W, 8, width of the sent and dropped counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_weight  in  WEIGHT_W  package weight offered by upstream
in_valid  in  1  in_weight is valid
in_ready  out  1  feeder can accept; a transfer occurs on an edge with in_valid && in_ready
weight  out  WEIGHT_W  registered weight bus to the sorter; 0 = scale empty
busy  out  1  FIFO non-empty or state != IDLE
sent_count  out  CNT_W  packages fully driven (wraps)
drop_count  out  CNT_W  zero-weight packages discarded (saturates at all-ones)

Behaviour:
- Reset (reset==0, asynchronous):
  - weight=0, state=IDLE, FIFO emptied, sent_count=0, drop_count=0, busy=0.
  - in_ready=0 while reset is asserted; in_ready=1 on the first cycle after release.
- Reset mid-operation aborts the current package immediately (weight drops to 0 without waiting for an edge). The aborted package is not counted.
- in_ready = !fifo_full. It is combinational from the FIFO count only, never from in_valid.
- On a transfer with in_weight != 0, the weight is written to the FIFO.
- On a transfer with in_weight == 0:
  - The package is accepted and discarded (no FIFO write, no bus activity).
  - drop_count increments, saturating at 2^CNT_W-1.
- FSM, states IDLE, HOLD, GAP; cnt is the internal down-counter:
  - IDLE: weight=0. On an edge with FIFO non-empty: pop the head, weight<=head, cnt<=HOLD_CYCLES-1, go to HOLD.
  - HOLD, cnt!=0: cnt<=cnt-1, weight unchanged.
  - HOLD, cnt==0: weight<=0, sent_count<=sent_count+1 (mod 2^CNT_W), cnt<=GAP_CYCLES-1, go to GAP.
  - GAP, cnt!=0: cnt<=cnt-1.
  - GAP, cnt==0, FIFO non-empty: pop the head and load it exactly as from IDLE, going to HOLD. This makes back-to-back packages with no extra idle cycle.
  - GAP, cnt==0, FIFO empty: go to IDLE.
- Bus timing: every package gives exactly HOLD_CYCLES cycles of nonzero weight, then at least GAP_CYCLES cycles of 0. Two nonzero weights are never adjacent.
- Latency: a transfer accepted at edge e into an empty FIFO with state IDLE appears on weight after edge e+1.
- Simultaneous push and pop in one edge:
  - Legal whenever in_ready is high; FIFO count is unchanged.
  - When full, in_ready is low, so no push occurs even if a pop happens that edge. in_ready rises the following cycle.
- FIFO order is strictly first-in first-out. Pointers wrap modulo FIFO_DEPTH.
- weight is a register output; no glitches, no combinational path from in_* to weight.

Decomposition:
- Shared constants file (sorter_defs):
  - WEIGHT_W.
  - State encodings IDLE=2'd0, HOLD=2'd1, GAP=2'd2.
  - CNT_W.
  - These are shared with the sorter and its bench.
- One sub-module, feeder_fifo: synchronous FIFO with push, pop, full, empty and head data, async active-low reset, depth FIFO_DEPTH.
- FSM, counters and handshake stay in package_feeder.

Test Plan:
- HOLD=1, GAP=1: push 100, 250, 550, 801, 1001, 2001 back-to-back.
  - Required: weight = 100,0,250,0,550,0,801,0,1001,0,2001,0, then stays 0.
  - Required: sent_count=6, busy falls one cycle after the last gap.
- HOLD=8: push 6 packages back-to-back.
  - Required: the first is popped immediately and 4 are buffered.
  - Required: in_ready=0 on the 6th offer; the 6th is accepted the cycle after the first pop from a full FIFO.
  - Required: all 6 appear in order.
- Push 0, then 300.
  - Required: drop_count=1, no bus pulse for the 0, weight=300 for HOLD cycles, sent_count=1.
- Assert reset in the middle of a HOLD of weight 1013 (HOLD=4).
  - Required: weight=0 before the next edge; FIFO empty; counters 0; resumes cleanly on new pushes after release.
- Push 256 packages of weight 5.
  - Required: sent_count wraps to 0.
- Push 300 zero-weight packages.
  - Required: drop_count holds at 255.
- HOLD=3, GAP=2: push 7 then 9.
  - Required: weight = 7,7,7,0,0,9,9,9,0,0.
